// File: rtl/sclk_burst_gen_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sclk_burst_gen_pkg
// Purpose  : Shared definitions for the SPI serial clock burst generator:
//            FSM state encoding, default widths and default timing constants.
// Revision : 1.0  initial release
// ============================================================================
package sclk_burst_gen_pkg;

   // FSM state encoding shared by the generator and anything that observes it
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOW  = 2'd1,
      ST_HIGH = 2'd2
   } state_t;

   // Default field widths
   localparam int DEF_CNT_W = 8;
   localparam int DEF_LEN_W = 16;

   // Default timing constants for the flash path
   localparam int DEF_LOW_COUNT  = 20;
   localparam int DEF_HIGH_COUNT = 2;
   localparam int DEF_STROBE_POS = 15;

   // sclk level driven while in a given state: HIGH phase is the inverse of CPOL
   function automatic logic phase_level(input state_t s, input logic cpol);
      return (s == ST_HIGH) ? ~cpol : cpol;
   endfunction

endpackage
`default_nettype wire

// File: rtl/sclk_burst_gen_if.sv
`default_nettype none
// ============================================================================
// Module   : sclk_burst_gen_if
// Purpose  : Handshake/config/status bundle between the SPI transaction
//            controller (master) and the serial clock generator (slave).
// Revision : 1.0  initial release
// ============================================================================
interface sclk_burst_gen_if
   import sclk_burst_gen_pkg::*;
#(
   parameter int CNT_W = DEF_CNT_W,
   parameter int LEN_W = DEF_LEN_W
) ();

   logic             start;
   logic             stop;
   logic [CNT_W-1:0] low_count;
   logic [CNT_W-1:0] high_count;
   logic [CNT_W-1:0] strobe_pos;
   logic [LEN_W-1:0] burst_len;
   logic             sclk;
   logic             launch_strobe;
   logic             rise_strobe;
   logic             busy;
   logic             done;
   logic [LEN_W-1:0] period_count;

   modport master (
      output start, stop, low_count, high_count, strobe_pos, burst_len,
      input  sclk, launch_strobe, rise_strobe, busy, done, period_count
   );

   modport slave (
      input  start, stop, low_count, high_count, strobe_pos, burst_len,
      output sclk, launch_strobe, rise_strobe, busy, done, period_count
   );

endinterface
`default_nettype wire

// File: rtl/sclk_burst_gen_phase_counter.sv
`default_nettype none
// ============================================================================
// Module   : sclk_phase_counter
// Purpose  : Clear/increment phase counter shared by the LOW and HIGH phases.
//            o_at_limit flags the last cycle of the current phase;
//            o_next_match flags that the value the counter takes next equals
//            i_match_val, so the caller can register a strobe that lines up
//            with the counter value.
// Revision : 1.0  initial release
// ============================================================================
module sclk_phase_counter
   import sclk_burst_gen_pkg::*;
#(
   parameter int CNT_W = DEF_CNT_W
) (
   input  wire logic             clk,
   input  wire logic             rst,
   input  wire logic             i_clr,
   input  wire logic             i_inc,
   input  wire logic [CNT_W-1:0] i_limit,
   input  wire logic [CNT_W-1:0] i_match_val,
   output logic                  o_at_limit,
   output logic                  o_next_match
);

   logic [CNT_W-1:0] count_q;
   logic [CNT_W-1:0] count_d;

   // Next count: clear (reload to zero) wins over increment, otherwise hold
   always_comb begin
      count_d = count_q;
      if (i_clr) begin
         count_d = '0;
      end else if (i_inc) begin
         count_d = count_q + 1'b1;
      end
      o_at_limit   = (count_q == i_limit);
      o_next_match = (count_d == i_match_val);
   end

   // Counter register
   always_ff @(posedge clk) begin
      if (rst) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

endmodule
`default_nettype wire

// File: rtl/sclk_burst_gen.sv
`default_nettype none
// ============================================================================
// Module   : sclk_burst_gen
// Purpose  : Run-time configurable SPI serial clock generator. Produces sclk
//            with programmable low/high phase lengths, a data-launch strobe
//            inside each low phase and a rise strobe, for a counted burst or
//            continuously until stopped. All outputs are registered.
// Revision : 1.0  initial release
// ============================================================================
module sclk_burst_gen
   import sclk_burst_gen_pkg::*;
#(
   parameter int   CNT_W = DEF_CNT_W,
   parameter int   LEN_W = DEF_LEN_W,
   parameter logic CPOL  = 1'b0
) (
   input wire logic        top_clk,
   input wire logic        rst,
   sclk_burst_gen_if.slave bus
);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] low_q, low_d;
   logic [CNT_W-1:0] high_q, high_d;
   logic [CNT_W-1:0] spos_q, spos_d;
   logic [LEN_W-1:0] blen_q, blen_d;
   logic [LEN_W-1:0] period_q, period_d;
   logic [LEN_W-1:0] period_inc;
   logic             stop_pend_q, stop_pend_d;
   logic             sclk_q, sclk_d;
   logic             launch_q, launch_d;
   logic             rise_q, rise_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;

   logic             cnt_clr;
   logic             cnt_inc;
   logic [CNT_W-1:0] cnt_limit;
   logic             cnt_at_limit;
   logic             cnt_next_match;
   logic             run_end;

   // One counter serves both phases; its terminal value follows the phase
   sclk_phase_counter #(
      .CNT_W (CNT_W)
   ) u_phase_cnt (
      .clk          (top_clk),
      .rst          (rst),
      .i_clr        (cnt_clr),
      .i_inc        (cnt_inc),
      .i_limit      (cnt_limit),
      .i_match_val  (spos_d),
      .o_at_limit   (cnt_at_limit),
      .o_next_match (cnt_next_match)
   );

   // Next-state, config latch, period counting and registered-output inputs
   always_comb begin
      state_d     = state_q;
      low_d       = low_q;
      high_d      = high_q;
      spos_d      = spos_q;
      blen_d      = blen_q;
      period_d    = period_q;
      stop_pend_d = stop_pend_q;
      cnt_clr     = 1'b0;
      cnt_inc     = 1'b0;
      run_end     = 1'b0;
      period_inc  = period_q + 1'b1;
      cnt_limit   = (state_q == ST_HIGH) ? high_q : low_q;

      case (state_q)
         ST_IDLE: begin
            if (bus.start) begin
               low_d    = bus.low_count;
               high_d   = bus.high_count;
               spos_d   = bus.strobe_pos;
               blen_d   = bus.burst_len;
               period_d = '0;
               cnt_clr  = 1'b1;
               state_d  = ST_LOW;
            end
         end
         ST_LOW: begin
            if (bus.stop) begin
               stop_pend_d = 1'b1;
            end
            if (cnt_at_limit) begin
               cnt_clr = 1'b1;
               state_d = ST_HIGH;
            end else begin
               cnt_inc = 1'b1;
            end
         end
         ST_HIGH: begin
            if (bus.stop) begin
               stop_pend_d = 1'b1;
            end
            if (cnt_at_limit) begin
               // Burst compare uses the latched length, so the wrap of
               // period_count in continuous mode never matters here.
               period_d = period_inc;
               run_end  = ((blen_q != '0) && (period_inc == blen_q))
                          || stop_pend_q || bus.stop;
               cnt_clr  = 1'b1;
               if (run_end) begin
                  stop_pend_d = 1'b0;
                  state_d     = ST_IDLE;
               end else begin
                  state_d = ST_LOW;
               end
            end else begin
               cnt_inc = 1'b1;
            end
         end
         default: begin
            state_d = ST_IDLE;
            cnt_clr = 1'b1;
         end
      endcase

      // Outputs are derived from the next state so they register in step
      sclk_d   = phase_level(state_d, CPOL);
      launch_d = (state_d == ST_LOW) && cnt_next_match;
      rise_d   = (state_d == ST_HIGH) && (state_q != ST_HIGH);
      busy_d   = (state_d != ST_IDLE);
      done_d   = (state_q == ST_HIGH) && (state_d == ST_IDLE);
   end

   // State, config and output registers
   always_ff @(posedge top_clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         low_q       <= '0;
         high_q      <= '0;
         spos_q      <= '0;
         blen_q      <= '0;
         period_q    <= '0;
         stop_pend_q <= 1'b0;
         sclk_q      <= CPOL;
         launch_q    <= 1'b0;
         rise_q      <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         low_q       <= low_d;
         high_q      <= high_d;
         spos_q      <= spos_d;
         blen_q      <= blen_d;
         period_q    <= period_d;
         stop_pend_q <= stop_pend_d;
         sclk_q      <= sclk_d;
         launch_q    <= launch_d;
         rise_q      <= rise_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
      end
   end

   assign bus.sclk          = sclk_q;
   assign bus.launch_strobe = launch_q;
   assign bus.rise_strobe   = rise_q;
   assign bus.busy          = busy_q;
   assign bus.done          = done_q;
   assign bus.period_count  = period_q;

endmodule
`default_nettype wire

// File: tb/tb_sclk_burst_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_sclk_burst_gen
// Purpose  : Scoreboard bench for sclk_burst_gen. Stimulus pushes expected
//            sclk/busy levels and strobe/done events; a monitor compares them
//            against a CPOL=0 and a CPOL=1 instance driven identically.
// Revision : 1.0  initial release
// ============================================================================
module tb_sclk_burst_gen;
   import sclk_burst_gen_pkg::*;

   localparam int CW = 8;
   localparam int LW = 16;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   sclk_burst_gen_if #(.CNT_W(CW), .LEN_W(LW)) bus0 ();
   sclk_burst_gen_if #(.CNT_W(CW), .LEN_W(LW)) bus1 ();

   assign bus1.start      = bus0.start;
   assign bus1.stop       = bus0.stop;
   assign bus1.low_count  = bus0.low_count;
   assign bus1.high_count = bus0.high_count;
   assign bus1.strobe_pos = bus0.strobe_pos;
   assign bus1.burst_len  = bus0.burst_len;

   sclk_burst_gen #(.CNT_W(CW), .LEN_W(LW), .CPOL(1'b0)) dut0 (
      .top_clk (clk),
      .rst     (rst),
      .bus     (bus0)
   );

   sclk_burst_gen #(.CNT_W(CW), .LEN_W(LW), .CPOL(1'b1)) dut1 (
      .top_clk (clk),
      .rst     (rst),
      .bus     (bus1)
   );

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct { int cyc; logic hi; logic busy; } lvl_t;
   typedef struct { int cyc; int pc; } done_t;
   lvl_t  lvl_q[$];
   int    launch_q[$];
   int    rise_q[$];
   done_t done_q[$];

   int checks   = 0;
   int failures = 0;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: actual=%0d required=%0d (cyc %0d)", name, act, exp, cyc);
      end
   endtask

   // Expected behaviour of one run, first LOW cycle at absolute cycle base.
   // Only events in spec cycles 1..limit are queued.
   task automatic plan(input int base, input int l, input int h, input int s,
                       input int nper, input bit with_done, input int pc,
                       input int limit);
      int c = base;
      for (int p = 0; p < nper; p++) begin
         for (int i = 0; i <= l; i++) begin
            if (c - base + 1 <= limit) begin
               lvl_q.push_back('{c, 1'b0, 1'b1});
               if (i == s) launch_q.push_back(c);
            end
            c++;
         end
         for (int i = 0; i <= h; i++) begin
            if (c - base + 1 <= limit) begin
               lvl_q.push_back('{c, 1'b1, 1'b1});
               if (i == 0) rise_q.push_back(c);
            end
            c++;
         end
      end
      if (with_done) begin
         done_q.push_back('{c, pc});
         lvl_q.push_back('{c, 1'b0, 1'b0});
      end
   endtask

   // Called at a negedge; start is sampled at the next posedge
   task automatic start_run(input int l, input int h, input int s, input int n);
      bus0.low_count  = CW'(l);
      bus0.high_count = CW'(h);
      bus0.strobe_pos = CW'(s);
      bus0.burst_len  = LW'(n);
      bus0.start      = 1'b1;
      @(negedge clk);
      bus0.start      = 1'b0;
   endtask

   task automatic wait_until(input int target);
      while (cyc < target) @(negedge clk);
   endtask

   // Monitor: compare DUT outputs against queued expectations every cycle
   always @(negedge clk) begin
      while (lvl_q.size() > 0 && lvl_q[0].cyc < cyc) begin
         check("level_missed", cyc, lvl_q[0].cyc);
         void'(lvl_q.pop_front());
      end
      if (lvl_q.size() > 0 && lvl_q[0].cyc == cyc) begin
         lvl_t e;
         e = lvl_q.pop_front();
         check("sclk_cpol0", int'(bus0.sclk), e.hi ? 1 : 0);
         check("sclk_cpol1", int'(bus1.sclk), e.hi ? 0 : 1);
         check("busy", int'(bus0.busy), int'(e.busy));
      end
      while (launch_q.size() > 0 && launch_q[0] < cyc) begin
         check("launch_missed", cyc, launch_q[0]);
         void'(launch_q.pop_front());
      end
      if (bus0.launch_strobe) begin
         if (launch_q.size() == 0) check("launch_unexpected", cyc, -1);
         else check("launch_cycle", cyc, launch_q.pop_front());
      end
      while (rise_q.size() > 0 && rise_q[0] < cyc) begin
         check("rise_missed", cyc, rise_q[0]);
         void'(rise_q.pop_front());
      end
      if (bus0.rise_strobe) begin
         if (rise_q.size() == 0) check("rise_unexpected", cyc, -1);
         else check("rise_cycle", cyc, rise_q.pop_front());
      end
      while (done_q.size() > 0 && done_q[0].cyc < cyc) begin
         check("done_missed", cyc, done_q[0].cyc);
         void'(done_q.pop_front());
      end
      if (bus0.done) begin
         if (done_q.size() == 0) check("done_unexpected", cyc, -1);
         else begin
            done_t d;
            d = done_q.pop_front();
            check("done_cycle", cyc, d.cyc);
            check("done_period_count", int'(bus0.period_count), d.pc);
         end
      end
   end

   // Watchdog so the run always ends
   initial begin
      #2_000_000;
      $display("FAIL watchdog: actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   // Directed stimulus
   initial begin
      int base;
      int base2;
      rst             = 1'b1;
      bus0.start      = 1'b0;
      bus0.stop       = 1'b0;
      bus0.low_count  = CW'(DEF_LOW_COUNT);
      bus0.high_count = CW'(DEF_HIGH_COUNT);
      bus0.strobe_pos = CW'(DEF_STROBE_POS);
      bus0.burst_len  = '0;
      repeat (3) @(negedge clk);
      check("rst_sclk0", int'(bus0.sclk), 0);
      check("rst_sclk1", int'(bus1.sclk), 1);
      check("rst_busy", int'(bus0.busy), 0);
      check("rst_done", int'(bus0.done), 0);
      check("rst_launch", int'(bus0.launch_strobe), 0);
      check("rst_rise", int'(bus0.rise_strobe), 0);
      check("rst_period_count", int'(bus0.period_count), 0);
      rst = 1'b0;
      @(negedge clk);

      // Default timing, continuous, stopped during the third LOW phase
      base = cyc + 1;
      plan(base, 20, 2, 15, 3, 1'b1, 3, 1000);
      start_run(20, 2, 15, 0);
      wait_until(base + 49);
      bus0.stop = 1'b1;
      @(negedge clk);
      bus0.stop = 1'b0;
      wait_until(base + 73);

      // Counted burst of 3
      base = cyc + 1;
      plan(base, 3, 1, 0, 3, 1'b1, 3, 1000);
      start_run(3, 1, 0, 3);
      wait_until(base + 19);
      check("period_count_hold", int'(bus0.period_count), 3);

      // Stop while in the first LOW phase
      base = cyc + 1;
      plan(base, 5, 1, 2, 1, 1'b1, 1, 1000);
      start_run(5, 1, 2, 0);
      wait_until(base + 2);
      bus0.stop = 1'b1;
      @(negedge clk);
      bus0.stop = 1'b0;
      wait_until(base + 9);

      // Minimum period: sclk toggles every cycle
      base = cyc + 1;
      plan(base, 0, 0, 0, 4, 1'b1, 4, 1000);
      start_run(0, 0, 0, 4);
      wait_until(base + 9);

      // Strobe position beyond low phase; start while busy is ignored
      base = cyc + 1;
      plan(base, 3, 1, 7, 2, 1'b1, 2, 1000);
      start_run(3, 1, 7, 2);
      wait_until(base + 2);
      bus0.low_count  = '0;
      bus0.high_count = '0;
      bus0.strobe_pos = '0;
      bus0.burst_len  = LW'(1);
      bus0.start      = 1'b1;
      @(negedge clk);
      bus0.start      = 1'b0;

      // Start on the done cycle of the previous run
      wait_until(base + 12);
      base2 = cyc + 1;
      plan(base2, 1, 0, 1, 1, 1'b1, 1, 1000);
      start_run(1, 0, 1, 1);
      check("period_count_cleared", int'(bus0.period_count), 0);
      wait_until(base2 + 4);

      // Reset during a HIGH phase, then a normal run
      base = cyc + 1;
      plan(base, 3, 3, 1, 1, 1'b0, 0, 5);
      start_run(3, 3, 1, 0);
      wait_until(base + 5);
      rst = 1'b1;
      @(negedge clk);
      check("abort_sclk0", int'(bus0.sclk), 0);
      check("abort_sclk1", int'(bus1.sclk), 1);
      check("abort_busy", int'(bus0.busy), 0);
      check("abort_done", int'(bus0.done), 0);
      check("abort_period_count", int'(bus0.period_count), 0);
      rst = 1'b0;
      @(negedge clk);
      base = cyc + 1;
      plan(base, 2, 1, 1, 1, 1'b1, 1, 1000);
      start_run(2, 1, 1, 1);
      wait_until(base + 8);

      check("level_left", lvl_q.size(), 0);
      check("launch_left", launch_q.size(), 0);
      check("rise_left", rise_q.size(), 0);
      check("done_left", done_q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
